// File: rtl/iter_divider.sv
// Iterative restoring radix-2 unsigned divider: one quotient bit per clock.
// Result c = {remainder, quotient}; divide-by-zero returns {a, all-ones} in one cycle.
module iter_divider #(
    parameter int WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   c
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] dividend_q;
    logic [WIDTH-1:0] divisor_q;
    logic [WIDTH-1:0] rem_q;
    logic [CW-1:0]    count_q;

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] rem_next;
    logic             fits;
    logic             last_step;

    // The compare is one bit wider than the operands so a divisor with its MSB set
    // is still compared correctly; the low bits of the difference are exact whenever it fits.
    always_comb begin
        shifted   = {rem_q, dividend_q[WIDTH-1]};
        fits      = (shifted >= {1'b0, divisor_q});
        diff      = shifted[WIDTH-1:0] - divisor_q;
        rem_next  = fits ? diff : shifted[WIDTH-1:0];
        last_step = (count_q == CW'(1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (valid) begin
                    state_next = (b != '0) ? BUSY : DONE;
                end
            end
            BUSY: begin
                if (!valid) begin
                    state_next = IDLE;
                end else if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        done = (state == DONE);
    end

    // The dividend register doubles as the quotient: each step shifts a dividend bit
    // out of the top and a quotient bit in at the bottom.
    always_ff @(posedge clk) begin
        if (reset) begin
            dividend_q <= '0;
            divisor_q  <= '0;
            rem_q      <= '0;
            count_q    <= '0;
            c          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid) begin
                        if (b != '0) begin
                            dividend_q <= a;
                            divisor_q  <= b;
                            rem_q      <= '0;
                            count_q    <= CW'(WIDTH);
                        end else begin
                            c <= {a, {WIDTH{1'b1}}};
                        end
                    end
                end
                BUSY: begin
                    if (valid) begin
                        dividend_q <= {dividend_q[WIDTH-2:0], fits};
                        rem_q      <= rem_next;
                        count_q    <= count_q - CW'(1);
                        if (last_step) begin
                            c <= {rem_next, dividend_q[WIDTH-2:0], fits};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iter_divider.sv
// Self-checking bench for iter_divider: directed vector table, abort and reset
// sequences, and randomized back-to-back operations against an arithmetic model.
module tb_iter_divider;

    logic         clk;
    logic         reset;
    logic         valid;
    logic [63:0]  a;
    logic [63:0]  b;
    logic         done;
    logic [127:0] c;

    int n_checks = 0;
    int n_fail   = 0;

    iter_divider #(.WIDTH(64)) dut (
        .clk   (clk),
        .reset (reset),
        .valid (valid),
        .a     (a),
        .b     (b),
        .done  (done),
        .c     (c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [63:0]  a;
        logic [63:0]  b;
        logic [127:0] exp_c;
        int           exp_lat;
    } vec_t;

    vec_t vecs[9];

    task automatic check_output(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Starts from IDLE with valid raised; returns c and the number of edges until done.
    task automatic apply_stimulus(input logic [63:0] av, input logic [63:0] bv, input bit perturb,
                                  output logic [127:0] got, output int lat);
        a     = av;
        b     = bv;
        valid = 1'b1;
        lat   = -1;
        got   = '0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                got = c;
                break;
            end
            if (perturb) begin
                a = {$urandom, $urandom};
                b = {$urandom, $urandom};
            end
        end
    endtask

    initial begin
        logic [127:0] got;
        logic [127:0] prev_c;
        logic [63:0]  ra;
        logic [63:0]  rb;
        int           lat;
        int           seen_done;

        vecs[0] = '{"div_100_7",     64'd100, 64'd7, {64'd2, 64'd14}, 65};
        vecs[1] = '{"div_max_1",     64'hFFFF_FFFF_FFFF_FFFF, 64'd1, {64'd0, 64'hFFFF_FFFF_FFFF_FFFF}, 65};
        vecs[2] = '{"div_5_10",      64'd5, 64'd10, {64'd5, 64'd0}, 65};
        vecs[3] = '{"div_msb",       64'h8000_0000_0000_0001, 64'h8000_0000_0000_0000, {64'd1, 64'd1}, 65};
        vecs[4] = '{"div_by_zero",   64'd42, 64'd0, {64'd42, 64'hFFFF_FFFF_FFFF_FFFF}, 1};
        vecs[5] = '{"div_9_4",       64'd9, 64'd4, {64'd1, 64'd2}, 65};
        vecs[6] = '{"div_max_max",   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, {64'd0, 64'd1}, 65};
        vecs[7] = '{"div_0_5",       64'd0, 64'd5, {64'd0, 64'd0}, 65};
        vecs[8] = '{"div_max_msb",   64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
                    {64'h7FFF_FFFF_FFFF_FFFF, 64'd1}, 65};

        reset = 1'b1;
        valid = 1'b1;
        a     = 64'd5;
        b     = 64'd3;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_done", {127'd0, done}, 128'd0);
        check_output("reset_c", c, 128'd0);
        reset = 1'b0;
        valid = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) begin
            apply_stimulus(vecs[i].a, vecs[i].b, 1'b0, got, lat);
            check_output({vecs[i].name, "_c"}, got, vecs[i].exp_c);
            check_output({vecs[i].name, "_latency"}, 128'(lat), 128'(vecs[i].exp_lat));
            valid = 1'b0;
            @(posedge clk);
            #1;
            check_output({vecs[i].name, "_done_pulse"}, {127'd0, done}, 128'd0);
        end

        // Abort: valid drops during cycle 30 of an operation.
        prev_c    = c;
        seen_done = 0;
        a         = 64'd100;
        b         = 64'd7;
        valid     = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (done) seen_done++;
        end
        valid = 1'b0;
        for (int k = 0; k < 80; k++) begin
            @(posedge clk);
            #1;
            if (done) seen_done++;
        end
        check_output("abort_no_done", 128'(seen_done), 128'd0);
        check_output("abort_c_held", c, prev_c);
        apply_stimulus(64'd20, 64'd3, 1'b0, got, lat);
        check_output("after_abort_c", got, {64'd2, 64'd6});
        check_output("after_abort_latency", 128'(lat), 128'd65);
        valid = 1'b0;
        @(posedge clk);
        #1;

        // Reset in cycle 40 of an operation.
        seen_done = 0;
        a         = 64'd100;
        b         = 64'd7;
        valid     = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done) seen_done++;
        end
        reset = 1'b1;
        valid = 1'b0;
        @(posedge clk);
        #1;
        check_output("midreset_done", {127'd0, done}, 128'd0);
        check_output("midreset_c", c, 128'd0);
        reset = 1'b0;
        for (int k = 0; k < 70; k++) begin
            @(posedge clk);
            #1;
            if (done) seen_done++;
        end
        check_output("midreset_no_done", 128'(seen_done), 128'd0);
        apply_stimulus(64'd9, 64'd4, 1'b0, got, lat);
        check_output("after_reset_c", got, {64'd1, 64'd2});
        check_output("after_reset_latency", 128'(lat), 128'd65);
        valid = 1'b0;
        @(posedge clk);
        #1;

        // Back-to-back random operations; new operands appear during the ignored done cycle.
        for (int i = 0; i < 400; i++) begin
            ra = {$urandom, $urandom};
            ra = ra >> $urandom_range(63, 0);
            rb = {$urandom, $urandom};
            rb = rb >> $urandom_range(63, 0);
            if (rb == 64'd0) rb = 64'd1;
            if (i > 0) begin
                a = ra;
                b = rb;
                @(posedge clk);
                #1;
                check_output("rand_idle_gap_done", {127'd0, done}, 128'd0);
            end
            apply_stimulus(ra, rb, 1'b1, got, lat);
            check_output("rand_c", got, {ra % rb, ra / rb});
            check_output("rand_latency", 128'(lat), 128'd65);
        end
        valid = 1'b0;
        @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
